// File: rtl/aes_mixcol_seq_if.sv
// Valid/ready bundle for aes_mixcol_seq: input state on one side, mixed state on the other.
// The bypass_i member exists only when AES_MIXCOL_BYPASS_EN is defined.
interface aes_mixcol_seq_if;
    logic         data_v_i;
    logic         data_ready_o;
    logic [127:0] data_i;
    logic         res_v_o;
    logic         res_ready_i;
    logic [127:0] res_o;
    logic         busy_o;
`ifdef AES_MIXCOL_BYPASS_EN
    logic         bypass_i;

    modport master (
        output data_v_i, data_i, res_ready_i, bypass_i,
        input  data_ready_o, res_v_o, res_o, busy_o
    );

    modport slave (
        input  data_v_i, data_i, res_ready_i, bypass_i,
        output data_ready_o, res_v_o, res_o, busy_o
    );
`else
    modport master (
        output data_v_i, data_i, res_ready_i,
        input  data_ready_o, res_v_o, res_o, busy_o
    );

    modport slave (
        input  data_v_i, data_i, res_ready_i,
        output data_ready_o, res_v_o, res_o, busy_o
    );
`endif
endinterface

// File: rtl/aes_mixcol_seq.sv
// AES MixColumns over a 128-bit state, time-multiplexing LANES aes_mixw column units.
// Optional AES_MIXCOL_BYPASS_EN adds bypass_i to skip mixing (final round).
module aes_mixw (
    input  logic [31:0] col,
    output logic [31:0] mixed
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] b0, b1, b2, b3;

    assign b0 = col[7:0];
    assign b1 = col[15:8];
    assign b2 = col[23:16];
    assign b3 = col[31:24];

    // Row r = 2*b[r] ^ 3*b[r+1] ^ b[r+2] ^ b[r+3], with 3*x = 2*x ^ x.
    assign mixed[7:0]   = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
    assign mixed[15:8]  = xtime(b1) ^ xtime(b2) ^ b2 ^ b3 ^ b0;
    assign mixed[23:16] = xtime(b2) ^ xtime(b3) ^ b3 ^ b0 ^ b1;
    assign mixed[31:24] = xtime(b3) ^ xtime(b0) ^ b0 ^ b1 ^ b2;
endmodule

module aes_mixcol_seq #(
    parameter int unsigned LANES = 1
) (
    input logic            clk,
    input logic            nreset,
    aes_mixcol_seq_if.slave bus
);
    localparam int unsigned STEPS = 4 / LANES;
    localparam logic [1:0]  LAST  = 2'(STEPS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("aes_mixcol_seq: LANES must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        MIX,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] st_q, st_d;
    logic [127:0] mixed_st;
    logic         ready;
    logic         accept;
    logic         bypass;

`ifdef AES_MIXCOL_BYPASS_EN
    assign bypass = bus.bypass_i;
`else
    assign bypass = 1'b0;
`endif

    logic [1:0]  lane_col [LANES];
    logic [31:0] lane_in  [LANES];
    logic [31:0] lane_out [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_col[l] = 2'(col_q * LANES + l);
        assign lane_in[l]  = st_q[{lane_col[l], 5'b0} +: 32];

        aes_mixw u_mixw (
            .col   (lane_in[l]),
            .mixed (lane_out[l])
        );
    end

    // Columns touched this cycle are overwritten in place; the rest pass through.
    always_comb begin
        mixed_st = st_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            mixed_st[{lane_col[l], 5'b0} +: 32] = lane_out[l];
        end
    end

    assign ready  = nreset & ((state_q == IDLE) | ((state_q == DONE) & bus.res_ready_i));
    assign accept = bus.data_v_i & ready;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        st_d    = st_q;
        case (state_q)
            IDLE, DONE: begin
                // In DONE a retire and a new accept share the edge, so no bubble.
                if (accept) begin
                    st_d    = bus.data_i;
                    col_d   = '0;
                    state_d = bypass ? DONE : MIX;
                end else if (state_q == DONE && bus.res_ready_i) begin
                    state_d = IDLE;
                end
            end
            MIX: begin
                st_d = mixed_st;
                if (col_q == LAST) begin
                    col_d   = '0;
                    state_d = DONE;
                end else begin
                    col_d = col_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= IDLE;
            col_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            st_q    <= st_d;
        end
    end

    assign bus.data_ready_o = ready;
    assign bus.res_v_o      = (state_q == DONE);
    assign bus.busy_o       = (state_q == MIX);
    assign bus.res_o        = st_q;
endmodule
